// File: rtl/clock_ctrl.sv
// Debounced single-step / auto-run clock-enable generator for a slow teaching CPU.
// The buttons are sampled at a low rate, press edges become one-cycle events, and the FSM turns them into o_clk_en pulses.
module clock_ctrl #(
  parameter int unsigned SAMPLE_DIV = 100000,
  parameter int unsigned DIV0       = 10000000,
  parameter int unsigned DIV1       = 1000000,
  parameter int unsigned DIV2       = 100000,
  parameter int unsigned DIV3       = 10000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn_step,
  input  logic       i_btn_mode,
  input  logic       i_btn_speed,
  input  logic       i_halt,
  output logic       o_clk_en,
  output logic       o_auto,
  output logic       o_halted,
  output logic [1:0] o_speed
);

  localparam int unsigned SW = $clog2(SAMPLE_DIV);
  localparam logic [SW-1:0] SMP_LAST = SW'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {S_MANUAL, S_AUTO, S_HALTED} state_t;

  // Button vectors are ordered {speed, mode, step}.
  localparam int B_STEP  = 0;
  localparam int B_MODE  = 1;
  localparam int B_SPEED = 2;

  logic [SW-1:0] r_smp_cnt;
  logic          w_strobe;
  logic [2:0]    r_sync1, r_sync2, r_prev, r_evt;

  state_t        r_state;
  logic [31:0]   r_rate;
  logic [31:0]   w_rate_last;
  logic          w_term;
  logic          r_clk_en, r_auto, r_halted;
  logic [1:0]    r_speed;

  assign w_strobe = (r_smp_cnt == SMP_LAST);

  // Sampling front end: synchronize, then edge-detect only on strobe cycles.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_smp_cnt <= '0;
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_prev    <= '0;
      r_evt     <= '0;
    end else begin
      r_smp_cnt <= w_strobe ? '0 : r_smp_cnt + 1'b1;
      r_sync1   <= {i_btn_speed, i_btn_mode, i_btn_step};
      r_sync2   <= r_sync1;
      if (w_strobe) begin
        r_prev <= r_sync2;
        r_evt  <= r_sync2 & ~r_prev;
      end else begin
        r_evt  <= '0;
      end
    end
  end

  always_comb begin
    w_rate_last = 32'(DIV0 - 1);
    case (r_speed)
      2'd0: w_rate_last = 32'(DIV0 - 1);
      2'd1: w_rate_last = 32'(DIV1 - 1);
      2'd2: w_rate_last = 32'(DIV2 - 1);
      2'd3: w_rate_last = 32'(DIV3 - 1);
      default: w_rate_last = 32'(DIV0 - 1);
    endcase
  end

  assign w_term = (r_rate == w_rate_last);

  // Speed events act in every state; later rate assignments below refine the clear.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_MANUAL;
      r_rate   <= '0;
      r_clk_en <= 1'b0;
      r_auto   <= 1'b0;
      r_halted <= 1'b0;
      r_speed  <= '0;
    end else begin
      r_clk_en <= 1'b0;
      if (r_evt[B_SPEED]) begin
        r_speed <= r_speed + 2'd1;
        r_rate  <= '0;
      end
      case (r_state)
        S_HALTED: ;
        default: begin
          if (i_halt) begin
            r_state  <= S_HALTED;
            r_auto   <= 1'b0;
            r_halted <= 1'b1;
          end else if (r_evt[B_MODE]) begin
            r_state <= (r_state == S_AUTO) ? S_MANUAL : S_AUTO;
            r_auto  <= (r_state != S_AUTO);
            r_rate  <= '0;
          end else if (r_state == S_MANUAL) begin
            r_clk_en <= r_evt[B_STEP];
          end else if (r_evt[B_SPEED]) begin
            r_rate <= '0;
          end else if (w_term) begin
            r_rate   <= '0;
            r_clk_en <= 1'b1;
          end else begin
            r_rate <= r_rate + 32'd1;
          end
        end
      endcase
    end
  end

  assign o_clk_en = r_clk_en;
  assign o_auto   = r_auto;
  assign o_halted = r_halted;
  assign o_speed  = r_speed;

endmodule

// File: tb/tb_clock_ctrl.sv
// Bench for clock_ctrl: a cycle-indexed reference model derived from the button
// history (sample times are plain arithmetic on the cycle number since reset).
module tb_clock_ctrl;
  localparam int SD = 4;
  localparam int D0 = 8, D1 = 4, D2 = 2, D3 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1, b_step = 1'b0, b_mode = 1'b0, b_speed = 1'b0, halt = 1'b0;
  logic o_clk_en, o_auto, o_halted;
  logic [1:0] o_speed;

  clock_ctrl #(.SAMPLE_DIV(SD), .DIV0(D0), .DIV1(D1), .DIV2(D2), .DIV3(D3)) dut (
    .i_clk(clk), .i_reset(rst), .i_btn_step(b_step), .i_btn_mode(b_mode),
    .i_btn_speed(b_speed), .i_halt(halt), .o_clk_en(o_clk_en), .o_auto(o_auto),
    .o_halted(o_halted), .o_speed(o_speed)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Model state: t = cycle number since the last reset edge.
  logic [2:0] raw [16];
  int   t = 0;
  int   m_st = 0;     // 0 manual, 1 auto, 2 halted
  int   m_spd = 0;
  int   anchor = 0;   // first cycle of the current auto period train
  logic m_en = 1'b0;
  logic [4:0] exp_v;
  int   pq [$];
  int   bad_t;
  logic [4:0] bad_got, bad_exp;

  function automatic int div_of(int s);
    case (s)
      0: return D0;
      1: return D1;
      2: return D2;
      default: return D3;
    endcase
  endfunction

  // Synchronized level seen in cycle s is the raw input of cycle s-2.
  function automatic logic lvl(int b, int s);
    logic [2:0] v;
    if (s < 2) return 1'b0;
    v = raw[(s - 2) % 16];
    return v[b];
  endfunction

  // A press event is visible in cycle tc when cycle tc-1 was a sample point.
  function automatic logic evt(int b, int tc);
    int s;
    s = tc - 1;
    if (s < SD - 1) return 1'b0;
    if ((s % SD) != SD - 1) return 1'b0;
    return lvl(b, s) && !(s >= 2 * SD - 1 && lvl(b, s - SD));
  endfunction

  task automatic tick();
    logic es, em, ep, term;
    int dv, nt;
    raw[t % 16] = {b_speed, b_mode, b_step};
    es = evt(0, t); em = evt(1, t); ep = evt(2, t);
    if (rst) begin
      m_st = 0; m_spd = 0; m_en = 1'b0; anchor = 0; nt = 0;
    end else begin
      m_en = 1'b0;
      if (m_st == 2) begin
        if (ep) m_spd = (m_spd + 1) % 4;
      end else begin
        dv = div_of(m_spd);
        term = (m_st == 1) && (((t - anchor) % dv) == dv - 1);
        if (halt) m_st = 2;
        else if (em) m_st = 1 - m_st;
        else if (m_st == 0 && es) m_en = 1'b1;
        else if (m_st == 1 && !ep && term) m_en = 1'b1;
        if (ep) m_spd = (m_spd + 1) % 4;
        if (halt || em || ep) anchor = t + 1;
      end
      nt = t + 1;
    end
    @(posedge clk);
    t = nt;
    @(negedge clk);
    exp_v = {m_en, (m_st == 1), (m_st == 2), 2'(m_spd)};
  endtask

  // Advances n cycles; counts pulses and model disagreements for the caller to judge.
  task automatic run(input int n, output int pulses, output int mism);
    pulses = 0; mism = 0;
    repeat (n) begin
      tick();
      if (o_clk_en === 1'b1) begin pulses++; pq.push_back(t); end
      if ({o_clk_en, o_auto, o_halted, o_speed} !== exp_v) begin
        if (mism == 0) begin bad_t = t; bad_got = {o_clk_en, o_auto, o_halted, o_speed}; bad_exp = exp_v; end
        mism++;
      end
    end
  endtask

  task automatic do_reset();
    int p, m;
    rst = 1'b1; b_step = 1'b0; b_mode = 1'b0; b_speed = 1'b0; halt = 1'b0;
    run(2, p, m);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int p, m;
    rst = 1'b1;
    run(3, p, m);
    checks++;
    if ({o_clk_en, o_auto, o_halted, o_speed} !== 5'b0) begin
      failures++; $display("FAIL reset_outputs got=%b exp=%b", {o_clk_en, o_auto, o_halted, o_speed}, 5'b0);
    end
    checks++;
    if (m !== 0) begin failures++; $display("FAIL reset_model mism=%0d t=%0d got=%b exp=%b", m, bad_t, bad_got, bad_exp); end
    rst = 1'b0;
  endtask

  task automatic test_step_held();
    int p, m, tp, s;
    do_reset();
    pq.delete();
    tp = t; b_step = 1'b1;
    run(40, p, m);
    b_step = 1'b0;
    s = tp + 2;
    while ((s % SD) != SD - 1) s++;
    checks++;
    if (p !== 1) begin failures++; $display("FAIL step_held_count got=%0d exp=1", p); end
    checks++;
    if (pq.size() == 0 || pq[0] !== s + 2) begin
      failures++; $display("FAIL step_latency got=%0d exp=%0d", (pq.size() == 0) ? -1 : pq[0], s + 2);
    end
    checks++;
    if (m !== 0) begin failures++; $display("FAIL step_model mism=%0d t=%0d got=%b exp=%b", m, bad_t, bad_got, bad_exp); end
  endtask

  task automatic test_auto_speed();
    int p, m, mt;
    logic gap_ok;
    mt = 0;
    do_reset();
    b_mode = 1'b1; run(2 * SD, p, m); mt += m;
    b_mode = 1'b0; run(4, p, m); mt += m;
    checks++;
    if (o_auto !== 1'b1) begin failures++; $display("FAIL auto_enter got=%b exp=1", o_auto); end
    pq.delete();
    run(32, p, m); mt += m;
    checks++;
    if (p !== 4) begin failures++; $display("FAIL auto_div8_count got=%0d exp=4", p); end
    gap_ok = 1'b1;
    for (int i = 0; i + 1 < pq.size(); i++) if (pq[i + 1] - pq[i] != D0) gap_ok = 1'b0;
    checks++;
    if (gap_ok !== 1'b1) begin failures++; $display("FAIL auto_div8_period got=%b exp=1", gap_ok); end
    repeat (3) begin
      b_speed = 1'b1; run(2 * SD, p, m); mt += m;
      b_speed = 1'b0; run(2 * SD, p, m); mt += m;
    end
    checks++;
    if (o_speed !== 2'd3) begin failures++; $display("FAIL speed_x3 got=%0d exp=3", o_speed); end
    run(10, p, m); mt += m;
    checks++;
    if (p !== 10) begin failures++; $display("FAIL div1_every_cycle got=%0d exp=10", p); end
    b_speed = 1'b1; run(2 * SD, p, m); mt += m;
    b_speed = 1'b0; run(2 * SD, p, m); mt += m;
    checks++;
    if (o_speed !== 2'd0) begin failures++; $display("FAIL speed_wrap got=%0d exp=0", o_speed); end
    checks++;
    if (mt !== 0) begin failures++; $display("FAIL auto_model mism=%0d t=%0d got=%b exp=%b", mt, bad_t, bad_got, bad_exp); end
  endtask

  task automatic test_mode_step_same();
    int p, m, mt;
    do_reset();
    b_mode = 1'b1; b_step = 1'b1;
    run(2 * SD, p, mt);
    b_mode = 1'b0; b_step = 1'b0;
    checks++;
    if (p !== 0) begin failures++; $display("FAIL mode_beats_step_pulse got=%0d exp=0", p); end
    run(4, p, m); mt += m;
    checks++;
    if (o_auto !== 1'b1) begin failures++; $display("FAIL mode_beats_step_auto got=%b exp=1", o_auto); end
    checks++;
    if (mt !== 0) begin failures++; $display("FAIL mode_step_model mism=%0d t=%0d got=%b exp=%b", mt, bad_t, bad_got, bad_exp); end
  endtask

  task automatic test_halt();
    int p, m, mt, pt;
    mt = 0;
    do_reset();
    b_mode = 1'b1; run(2 * SD, p, m); mt += m;
    b_mode = 1'b0; run(4, p, m); mt += m;
    halt = 1'b1; run(1, p, m); mt += m;
    halt = 1'b0;
    checks++;
    if ({o_halted, o_auto, o_clk_en} !== 3'b100) begin
      failures++; $display("FAIL halt_enter got=%b exp=100", {o_halted, o_auto, o_clk_en});
    end
    b_step = 1'b1; b_mode = 1'b1; run(2 * SD, pt, m); mt += m;
    b_step = 1'b0; b_mode = 1'b0; run(2 * SD, p, m); mt += m; pt += p;
    halt = 1'b1; run(2, p, m); mt += m; pt += p;
    halt = 1'b0;
    checks++;
    if (pt !== 0) begin failures++; $display("FAIL halt_no_pulse got=%0d exp=0", pt); end
    checks++;
    if ({o_halted, o_auto} !== 2'b10) begin failures++; $display("FAIL halt_sticky got=%b exp=10", {o_halted, o_auto}); end
    b_speed = 1'b1; run(2 * SD, p, m); mt += m;
    b_speed = 1'b0; run(2 * SD, p, m); mt += m;
    checks++;
    if (o_speed !== 2'd1) begin failures++; $display("FAIL halt_speed got=%0d exp=1", o_speed); end
    checks++;
    if (mt !== 0) begin failures++; $display("FAIL halt_model mism=%0d t=%0d got=%b exp=%b", mt, bad_t, bad_got, bad_exp); end
  endtask

  task automatic test_reset_in_event();
    int p, m, mt, tp, s, guard;
    mt = 0;
    do_reset();
    tp = t; b_step = 1'b1;
    s = tp + 2;
    while ((s % SD) != SD - 1) s++;
    guard = 0;
    while (t < s + 1 && guard < 100) begin run(1, p, m); mt += m; guard++; end
    rst = 1'b1; b_step = 1'b0;
    run(1, p, m); mt += m;
    checks++;
    if ({o_clk_en, o_auto, o_halted, o_speed} !== 5'b0) begin
      failures++; $display("FAIL rst_in_event_outputs got=%b exp=%b", {o_clk_en, o_auto, o_halted, o_speed}, 5'b0);
    end
    rst = 1'b0;
    run(12, p, m); mt += m;
    checks++;
    if (p !== 0) begin failures++; $display("FAIL rst_in_event_pulse got=%0d exp=0", p); end
    checks++;
    if (mt !== 0) begin failures++; $display("FAIL rst_event_model mism=%0d t=%0d got=%b exp=%b", mt, bad_t, bad_got, bad_exp); end
  endtask

  // One-cycle pulses placed where no sample point can see them.
  task automatic test_glitch();
    int p, m, mt, pt, guard;
    mt = 0; pt = 0;
    do_reset();
    for (int b = 0; b < 3; b++) begin
      guard = 0;
      while ((t % SD) != SD - 1 && guard < 2 * SD) begin run(1, p, m); mt += m; pt += p; guard++; end
      {b_speed, b_mode, b_step} = 3'(1 << b);
      run(1, p, m); mt += m; pt += p;
      {b_speed, b_mode, b_step} = 3'b000;
      run(3 * SD, p, m); mt += m; pt += p;
    end
    checks++;
    if ({pt != 0, o_auto, o_speed} !== 4'b0) begin
      failures++; $display("FAIL glitch_ignored got=pulses:%0d auto:%b speed:%0d exp=0/0/0", pt, o_auto, o_speed);
    end
    checks++;
    if (mt !== 0) begin failures++; $display("FAIL glitch_model mism=%0d t=%0d got=%b exp=%b", mt, bad_t, bad_got, bad_exp); end
  endtask

  task automatic test_random();
    int p, m, mt, pt;
    mt = 0; pt = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) b_step  = ~b_step;
      if ($urandom_range(0, 9) == 0) b_mode  = ~b_mode;
      if ($urandom_range(0, 7) == 0) b_speed = ~b_speed;
      halt = ($urandom_range(0, 199) == 0);
      rst  = ($urandom_range(0, 299) == 0);
      run(1, p, m); mt += m; pt += p;
    end
    rst = 1'b0; halt = 1'b0;
    checks++;
    if (mt !== 0) begin failures++; $display("FAIL random_model mism=%0d t=%0d got=%b exp=%b", mt, bad_t, bad_got, bad_exp); end
    checks++;
    if (pt == 0) begin failures++; $display("FAIL random_activity got=%0d exp=>0", pt); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_step_held();
    test_auto_speed();
    test_mode_step_same();
    test_halt();
    test_reset_in_event();
    test_glitch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
